sync_fifo_buf: RTL and testbench
================================

Name: sync_fifo_buf

Overview:
- Parametrised synchronous FIFO. Successor to the plain dual-address register-file storage used in the UART datapath.
- Adds internal pointer management, occupancy counting, full/empty/almost flags and show-ahead read data.
- Sits between the UART receiver/transmitter and the host-side interface, decoupling bursty producers from consumers.
- One instance per direction (RX FIFO, TX FIFO).

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, pointer width; depth DEPTH = 2**ADDR_WIDTH
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
wr  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd  in  1  read request (pop)
rd_data  out  DATA_WIDTH  word at head of queue (show-ahead)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; present only with FIFO_ERR_FLAGS_EN
underflow  out  1  sticky; present only with FIFO_ERR_FLAGS_EN

Behaviour:
- Reset: clk and rst are the only clock/reset. Reset is synchronous and active-high.
- Values on rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Storage contents are not reset. rd_data is undefined while empty.
- Reset mid-operation discards all stored words and wins over simultaneous wr/rd.
- Storage is DEPTH x DATA_WIDTH. Write is synchronous on wr_ptr; read is asynchronous at rd_ptr.
- rd_data = mem[rd_ptr] combinationally, so the head word is valid whenever empty=0. A pop advances to the next word on the following cycle.
- Effective operations:
  - wr_eff = wr & (~full | rd)
  - rd_eff = rd & ~empty
- On wr_eff: mem[wr_ptr] <= wr_data, then wr_ptr <= wr_ptr+1.
- On rd_eff: rd_ptr <= rd_ptr+1.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH with no explicit compare.
- count update:
  - +1 on wr_eff only
  - -1 on rd_eff only
  - unchanged when both or neither occur
- Flags are registered from the next count, so they are valid in the same cycle count updates.
- Full with wr=1 and rd=1: both occur, count stays DEPTH, full stays 1.
- Empty with wr=1 and rd=1: write only, read ignored, count becomes 1. Underflow is flagged if enabled.
- Full with wr=1 and rd=0: write dropped, storage unchanged. Overflow is flagged if enabled.
- Empty with rd=1 and wr=0: no pointer change. Underflow is flagged if enabled.
- Latency: a word written in cycle N appears on rd_data in cycle N+1 when the FIFO was empty. There is no bypass from wr_data to rd_data.
- No state machine beyond the count.
- Elaboration check: AE_LEVEL < AF_LEVEL <= DEPTH; $error otherwise.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow and underflow ports exist.
  - overflow sets on (wr & full & ~rd); underflow sets on (rd & empty).
  - Both stay set until rst.
- Undefined:
  - Both ports and their logic are absent.
  - Dropped writes and ignored reads are silent.
- All other behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH localparams
  - typedef for the count type (logic [ADDR_WIDTH:0])
  - function next_count(count, wr_eff, rd_eff)
- Sub-module fifo_mem holds the storage only: one write port (clk, we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count and flag logic stays in sync_fifo_buf.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, almost_empty=1, error flags 0.
- Write 0x11,0x22,0x33 on consecutive cycles, then read 3 → rd_data shows 0x11, 0x22, 0x33 in order; count goes 1,2,3,2,1,0; empty returns to 1.
- Defaults (DEPTH=16): write 16 words → full=1 on the cycle count=16; almost_full=1 from count=14. A 17th write with rd=0 is dropped: count stays 16 and overflow=1 (macro on).
- Full with wr=1, rd=1 for 20 cycles using incrementing data → count stays 16, ordering preserved across pointer wrap, data read matches data written 16 pops earlier.
- Empty with rd=1, wr=1, data 0xA5 → count=1 next cycle, rd_data=0xA5, underflow=1 (macro on).
- Fill to 8, assert rst for one cycle while wr=1 → count=0 and empty=1 next cycle; the following write/read of 0x5A returns 0x5A.

Source files
------------

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO (sync_fifo_buf) and its
// storage (fifo_mem).
//   FIFO_DATA_WIDTH / FIFO_ADDR_WIDTH : default geometry (8-bit words, 16 deep)
//   count_t                           : occupancy type at the default geometry
//   next_count()                      : occupancy update rule, written on a
//                                       32-bit container so any instance width
//                                       can use it and truncate the result
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;

    // One extra bit so that a completely full FIFO (count == DEPTH) is
    // distinguishable from an empty one.
    typedef logic [FIFO_ADDR_WIDTH:0] count_t;

    // Occupancy moves by one only when exactly one of push/pop happens.
    function automatic logic [31:0] next_count(input logic [31:0] cnt,
                                               input logic        wr_eff,
                                               input logic        rd_eff);
        logic [31:0] res;
        res = cnt;
        if (wr_eff && !rd_eff) begin
            res = cnt + 32'd1;
        end else if (rd_eff && !wr_eff) begin
            res = cnt - 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
// Storage array for sync_fifo_buf: DEPTH x DATA_WIDTH, contents not reset.
// Ports:
//   clk   : write clock
//   we    : write enable, word captured on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous / combinational read)
//   rdata : mem[raddr]
// ----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_buf.sv
// ----------------------------------------------------------------------------
// sync_fifo_buf
// Parametrised single-clock FIFO with show-ahead read data. Used once per
// direction between the UART datapath and the host-side interface.
// Ports:
//   clk          : single clock, all state updates on the rising edge
//   rst          : synchronous active-high reset (wins over wr/rd)
//   wr, wr_data  : push request and word
//   rd           : pop request
//   rd_data      : word at the head of the queue (valid while empty == 0)
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, write attempted while full without a pop
//   underflow    : sticky, pop attempted while empty
// Optional build macro: FIFO_ERR_FLAGS_EN adds overflow/underflow; without
// it dropped writes and ignored reads are silent.
// ----------------------------------------------------------------------------
module sync_fifo_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_level_check
        $error("sync_fifo_buf: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  wr_eff, rd_eff;

    // A write into a full FIFO is still legal when a pop frees the head slot
    // in the same cycle; a pop from an empty FIFO never happens.
    assign wr_eff  = wr & (~full_q | rd);
    assign rd_eff  = rd & ~empty_q;
    assign count_d = (ADDR_WIDTH+1)'(next_count(32'(count_q), wr_eff, rd_eff));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            // Pointers wrap naturally modulo DEPTH.
            if (wr_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            // Flags come from the next count so they line up with count_q.
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == (ADDR_WIDTH+1)'(DEPTH));
            aempty_q <= (count_d <= AE_THR);
            afull_q  <= (count_d >= AF_THR);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_eff & ~rst),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr & full_q & ~rd) overflow_q  <= 1'b1;
            if (rd & empty_q)      underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_buf.sv
module tb_sync_fifo_buf;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [DW-1:0] wr_data;
  logic          rd;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_buf #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .wr_data      (wr_data),
    .rd           (rd),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

`ifndef FIFO_ERR_FLAGS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // ---------------- scoreboard / reference model ----------------
  // The queue holds the words the FIFO should contain, head at index 0.
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  logic          exp_unf;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
    int sz;
    sz = exp_q.size();
    if (rs) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (w && sz == DEPTH && !r) exp_ovf = 1'b1;
      if (r && sz == 0)           exp_unf = 1'b1;
      if (r && sz > 0)            void'(exp_q.pop_front());
      if (w && (sz < DEPTH || r)) exp_q.push_back(d);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check("count", 32'(count), 32'(sz));
    check("empty", 32'(empty), 32'(sz == 0));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("almost_full", 32'(almost_full), 32'(sz >= AF));
    check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    if (sz > 0) check("rd_data", 32'(rd_data), 32'(exp_q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
    wr      = w;
    wr_data = d;
    rd      = r;
    rst     = rs;
    @(posedge clk);
    model_edge(w, d, r, rs);
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    wr = 1'b0; rd = 1'b0; wr_data = '0; rst = 1'b1;
    #1;

    // reset then idle
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);

    // three writes then three reads, show-ahead order
    cyc(1, 8'h11, 0, 0);
    check("first_word", 32'(rd_data), 32'h11);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(0, 8'h00, 1, 0);
    check("second_word", 32'(rd_data), 32'h22);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    check("drained", 32'(empty), 32'd1);

    // fill to full, then a dropped 17th write
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    check("full_at_16", 32'(full), 32'd1);
    cyc(1, 8'hEE, 0, 0);
    check("drop_count", 32'(count), 32'(DEPTH));
    check("drop_head", 32'(rd_data), 32'h40);

    // full with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h80 + i), 1, 0);
    check("wrap_count", 32'(count), 32'(DEPTH));

    // drain, then push+pop on empty
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hA5, 1, 0);
    check("empty_wr_rd_count", 32'(count), 32'd1);
    check("empty_wr_rd_data", 32'(rd_data), 32'hA5);
    cyc(0, 8'h00, 1, 0);

    // fill to 8, reset while writing, then reuse
    for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'hFF, 0, 1);
    check("mid_rst_count", 32'(count), 32'd0);
    cyc(1, 8'h5A, 0, 0);
    check("post_rst_data", 32'(rd_data), 32'h5A);
    cyc(0, 8'h00, 1, 0);

    // randomized traffic in write-heavy, balanced and read-heavy regimes
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      case ((i / 250) % 3)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 50; rp = 50; end
        default: begin wp = 25; rp = 80; end
      endcase
      cyc(($urandom_range(0, 99) < wp), 8'($urandom),
          ($urandom_range(0, 99) < rp), ($urandom_range(0, 399) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
